// File: rtl/rv32_stim_pkg.sv
// Shared types and constants for the RV32I stimulus generator.
// build_word turns one LFSR state into an R-type, I-type or NOP instruction word.
package rv32_stim_pkg;

   localparam logic [6:0]  OP_REG    = 7'b0110011;
   localparam logic [6:0]  OP_IMM    = 7'b0010011;
   localparam logic [31:0] NOP       = 32'h00000013;
   localparam logic [11:0] MASK_SLLI = 12'h01F;
   localparam logic [11:0] MASK_SRXI = 12'h41F;

   typedef enum logic [1:0] {
      MODE_R   = 2'd0,
      MODE_I   = 2'd1,
      MODE_MIX = 2'd2,
      MODE_NOP = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_WARMUP = 2'd0,
      ST_RUN    = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   function automatic logic [31:0] build_word(input mode_e      mode,
                                              input logic [31:0] s,
                                              input logic        force_rs1,
                                              input logic [4:0]  prev_rd);
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [11:0] imm;
      logic [6:0]  f7;
      logic        use_r;
      rd    = s[4:0];
      rs1   = force_rs1 ? prev_rd : s[9:5];
      rs2   = s[14:10];
      f3    = s[17:15];
      imm   = s[29:18];
      use_r = (mode == MODE_R) || ((mode == MODE_MIX) && s[31]);
      f7    = (s[30] && (f3 == 3'd0 || f3 == 3'd5)) ? 7'b0100000 : 7'b0000000;
      // shift-immediates keep only shamt, plus the arithmetic bit for SRAI
      if (f3 == 3'd1)
         imm = imm & MASK_SLLI;
      else if (f3 == 3'd5)
         imm = imm & MASK_SRXI;
      if (mode == MODE_NOP)
         build_word = NOP;
      else if (use_r)
         build_word = {f7, rs2, rs1, f3, rd, OP_REG};
      else
         build_word = {imm, rs1, f3, rd, OP_IMM};
   endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit Galois LFSR with seed load (zero seed replaced by 1) and step enable.
// o_next is the value the register takes at the coming edge.
module lfsr32_galois #(
   parameter logic [31:0] TAPS = 32'h80200003
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_load,
   input  logic [31:0] i_seed,
   input  logic        i_step,
   output logic [31:0] o_next
);

   logic [31:0] r_state;
   logic [31:0] w_stepped;

   assign w_stepped = (r_state >> 1) ^ (r_state[0] ? TAPS : 32'h0);

   always_comb begin
      o_next = r_state;
      if (i_load)
         o_next = (i_seed == 32'h0) ? 32'h1 : i_seed;
      else if (i_step)
         o_next = w_stepped;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset)
         r_state <= 32'h1;
      else
         r_state <= o_next;
   end

endmodule

// File: rtl/rv32_instr_stim_gen.sv
// Seedable RV32I instruction source: NOP warm-up, random ALU words, hazard
// injection and an instruction budget, all advancing only on a valid/ready fire.
module rv32_instr_stim_gen
   import rv32_stim_pkg::*;
#(
   parameter int unsigned WARMUP_NOPS   = 2,
   parameter int unsigned HAZARD_PERIOD = 4,
   parameter logic [31:0] LFSR_TAPS     = 32'h80200003
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [1:0]  i_cfg_mode,
   input  logic [31:0] i_cfg_seed,
   input  logic        i_cfg_load_seed,
   input  logic        i_cfg_hazard_en,
   input  logic [31:0] i_cfg_max_instrs,
   input  logic        i_instr_ready,
   output logic        o_instr_valid,
   output logic [31:0] o_instr,
   output logic [31:0] o_instr_count,
   output logic        o_done
);

   // state     | meaning
   // ST_WARMUP | emit WARMUP_NOPS NOPs, then register the first random word
   // ST_RUN    | present registered random word, regenerate on each fire
   // ST_DONE   | budget exhausted, valid low until reset

   localparam int unsigned WARM_W = (WARMUP_NOPS > 0) ? $clog2(WARMUP_NOPS + 1) : 1;
   localparam int unsigned HZ_W   = (HAZARD_PERIOD > 1) ? $clog2(HAZARD_PERIOD) : 1;
   localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_NOPS - 1);
   localparam logic [HZ_W-1:0]   HZ_LAST   = HZ_W'(HAZARD_PERIOD - 1);

   state_e            r_state;
   logic              r_valid;
   logic [31:0]       r_instr;
   logic [31:0]       r_count;
   logic [WARM_W-1:0] r_warm;
   logic [HZ_W-1:0]   r_hz_cnt;
   logic [4:0]        r_prev_rd;

   state_e            w_state_nxt;
   logic              w_valid_nxt;
   logic [31:0]       w_instr_nxt;
   logic [31:0]       w_count_nxt;
   logic [WARM_W-1:0] w_warm_nxt;
   logic [HZ_W-1:0]   w_hz_nxt;
   logic [4:0]        w_prev_nxt;
   logic              w_gen;
   logic              w_fire;
   logic              w_step;
   logic              w_hz_hit;
   logic [31:0]       w_lfsr_nxt;
   logic [31:0]       w_word;

   assign w_fire   = r_valid & i_instr_ready;
   assign w_step   = (r_state == ST_RUN) & w_fire;
   assign w_hz_hit = i_cfg_hazard_en & (r_hz_cnt == HZ_LAST);
   // built from the post-load/post-step value so seed loads apply to the next word
   assign w_word   = build_word(mode_e'(i_cfg_mode), w_lfsr_nxt, w_hz_hit, r_prev_rd);

   lfsr32_galois #(.TAPS(LFSR_TAPS)) u_lfsr (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_load  (i_cfg_load_seed),
      .i_seed  (i_cfg_seed),
      .i_step  (w_step),
      .o_next  (w_lfsr_nxt)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= ST_WARMUP;
         r_valid   <= 1'b0;
         r_instr   <= NOP;
         r_count   <= 32'h0;
         r_warm    <= '0;
         r_hz_cnt  <= '0;
         r_prev_rd <= 5'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_valid   <= w_valid_nxt;
         r_instr   <= w_instr_nxt;
         r_count   <= w_count_nxt;
         r_warm    <= w_warm_nxt;
         r_hz_cnt  <= w_hz_nxt;
         r_prev_rd <= w_prev_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_valid_nxt = r_valid;
      w_instr_nxt = r_instr;
      w_count_nxt = r_count;
      w_warm_nxt  = r_warm;
      w_hz_nxt    = r_hz_cnt;
      w_prev_nxt  = r_prev_rd;
      w_gen       = 1'b0;
      case (r_state)
         ST_WARMUP: begin
            w_valid_nxt = 1'b1;
            if (WARMUP_NOPS == 0) begin
               w_gen       = 1'b1;
               w_state_nxt = ST_RUN;
            end else if (w_fire) begin
               w_warm_nxt = r_warm + 1'b1;
               if (r_warm == WARM_LAST) begin
                  w_gen       = 1'b1;
                  w_state_nxt = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (w_fire) begin
               w_count_nxt = r_count + 32'd1;
               if ((i_cfg_max_instrs != 32'h0) && (w_count_nxt == i_cfg_max_instrs)) begin
                  w_state_nxt = ST_DONE;
                  w_valid_nxt = 1'b0;
                  w_instr_nxt = NOP;
               end else begin
                  w_gen = 1'b1;
               end
            end
         end
         ST_DONE: begin
            w_valid_nxt = 1'b0;
            w_instr_nxt = NOP;
         end
         default: begin
            w_state_nxt = ST_WARMUP;
         end
      endcase
      if (w_gen) begin
         w_instr_nxt = w_word;
         w_hz_nxt    = (r_hz_cnt == HZ_LAST) ? '0 : r_hz_cnt + 1'b1;
         w_prev_nxt  = w_lfsr_nxt[4:0];
      end
   end

   assign o_instr_valid = r_valid;
   assign o_instr       = r_instr;
   assign o_instr_count = r_count;
   assign o_done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_rv32_instr_stim_gen.sv
// Scoreboard bench for rv32_instr_stim_gen: directed scenarios push expected
// (word, count) pairs; a negedge monitor pops and compares on every fire.
module tb_rv32_instr_stim_gen;

   logic        clk = 1'b0;
   logic        i_reset = 1'b1;
   logic [1:0]  i_cfg_mode = 2'd0;
   logic [31:0] i_cfg_seed = 32'h0;
   logic        i_cfg_load_seed = 1'b0;
   logic        i_cfg_hazard_en = 1'b0;
   logic [31:0] i_cfg_max_instrs = 32'h0;
   logic        i_instr_ready = 1'b0;
   logic        o_instr_valid;
   logic [31:0] o_instr;
   logic [31:0] o_instr_count;
   logic        o_done;

   always #5 clk = ~clk;

   rv32_instr_stim_gen dut (
      .i_clk            (clk),
      .i_reset          (i_reset),
      .i_cfg_mode       (i_cfg_mode),
      .i_cfg_seed       (i_cfg_seed),
      .i_cfg_load_seed  (i_cfg_load_seed),
      .i_cfg_hazard_en  (i_cfg_hazard_en),
      .i_cfg_max_instrs (i_cfg_max_instrs),
      .i_instr_ready    (i_instr_ready),
      .o_instr_valid    (o_instr_valid),
      .o_instr          (o_instr),
      .o_instr_count    (o_instr_count),
      .o_done           (o_done)
   );

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] count;
   } exp_t;

   exp_t q[$];
   exp_t e_mon;
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] instr, input logic [31:0] count);
      q.push_back('{instr: instr, count: count});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!i_reset && o_instr_valid && i_instr_ready) begin
         if (q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_fire: got instr %h count %0d expected no fire", o_instr, o_instr_count);
         end else begin
            e_mon = q.pop_front();
            chk("fire_word", o_instr, e_mon.instr);
            chk("fire_count", o_instr_count, e_mon.count);
         end
      end
   end

   task automatic do_reset(input logic ready_during);
      i_instr_ready = ready_during;
      i_reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_valid", {31'h0, o_instr_valid}, 32'h0);
         chk("rst_instr", o_instr, 32'h00000013);
      end
      chk("rst_count", o_instr_count, 32'h0);
      chk("rst_done", {31'h0, o_done}, 32'h0);
      i_reset = 1'b0;
      i_instr_ready = 1'b0;
   endtask

   task automatic drain(input int budget);
      int k;
      k = 0;
      i_instr_ready = 1'b1;
      while (q.size() != 0 && k < budget) begin
         tick();
         k++;
      end
      i_instr_ready = 1'b0;
      n_checks++;
      if (q.size() != 0) begin
         n_errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
         q.delete();
      end
   endtask

   task automatic load_seed(input logic [31:0] seed);
      i_cfg_seed = seed;
      i_cfg_load_seed = 1'b1;
      tick();
      i_cfg_load_seed = 1'b0;
   endtask

   typedef struct packed {
      logic [1:0]  mode;
      logic [31:0] seed;
      logic [31:0] word;
   } vec_t;

   vec_t vecs[4];

   initial begin
      vecs[0] = '{mode: 2'd1, seed: 32'h3FFC80E5, word: 32'h01F39293};
      vecs[1] = '{mode: 2'd1, seed: 32'h3FFE80E5, word: 32'h41F3D293};
      vecs[2] = '{mode: 2'd2, seed: 32'hC0028CE5, word: 32'h4033D2B3};
      vecs[3] = '{mode: 2'd2, seed: 32'h3FFC80E5, word: 32'h01F39293};

      // reset with ready high, seed 1, R mode, hazard off
      do_reset(1'b1);
      push(32'h13, 0); push(32'h13, 0);
      push(32'h000000B3, 0); push(32'h000001B3, 1);
      push(32'h40000133, 2); push(32'h400000B3, 3);
      drain(40);

      // back-pressure: word and count hold; mode change only affects the next word
      i_cfg_mode = 2'd1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_instr", o_instr, 32'h000001B3);
         chk("hold_count", o_instr_count, 32'd4);
      end
      push(32'h000001B3, 4);
      i_instr_ready = 1'b1;
      tick();
      i_instr_ready = 1'b0;
      tick();
      chk("step_count", o_instr_count, 32'd5);
      chk("step_instr", o_instr, 32'h60D04113);
      chk("step_valid", {31'h0, o_instr_valid}, 32'h1);
      i_cfg_mode = 2'd0;

      // reset mid-handshake, then nonzero seed followed by zero seed
      do_reset(1'b1);
      load_seed(32'hDEADBEEF);
      load_seed(32'h0);
      push(32'h13, 0); push(32'h13, 0);
      push(32'h000000B3, 0); push(32'h000001B3, 1);
      drain(40);

      // I / mixed mode field shaping from loaded seeds
      for (int v = 0; v < 4; v++) begin
         i_cfg_mode = vecs[v].mode;
         do_reset(1'b0);
         load_seed(vecs[v].seed);
         push(32'h13, 0); push(32'h13, 0);
         push(vecs[v].word, 0);
         drain(40);
      end

      // NOP-only mode still counts
      i_cfg_mode = 2'd3;
      do_reset(1'b0);
      push(32'h13, 0); push(32'h13, 0);
      push(32'h13, 0); push(32'h13, 1); push(32'h13, 2);
      drain(40);
      tick();
      chk("nop_count", o_instr_count, 32'd3);

      // budget of 5 with hazard injection on the 4th random word
      i_cfg_mode = 2'd0;
      i_cfg_hazard_en = 1'b1;
      i_cfg_max_instrs = 32'd5;
      do_reset(1'b0);
      push(32'h13, 0); push(32'h13, 0);
      push(32'h000000B3, 0); push(32'h000001B3, 1);
      push(32'h40000133, 2); push(32'h400100B3, 3);
      push(32'h000001B3, 4);
      drain(40);
      chk("done_flag", {31'h0, o_done}, 32'h1);
      chk("done_valid", {31'h0, o_instr_valid}, 32'h0);
      chk("done_count", o_instr_count, 32'd5);
      chk("done_instr", o_instr, 32'h13);
      i_instr_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      i_instr_ready = 1'b0;
      chk("done_sticky", {31'h0, o_done}, 32'h1);
      do_reset(1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
